// File: rtl/math_multiplier_8bit_seq_if.sv
// ---------------------------------------------------------------------------
// math_multiplier_8bit_seq_if
//   Request/result bundle between the calculator control FSM (master) and the
//   sequential shift-and-add multiplier (slave).
//   start      master->slave  request, honoured only while the multiplier is idle
//   a, b       master->slave  unsigned operands, sampled on acceptance
//   mulResult  slave->master  registered product, held until the next completion
//   busy       slave->master  high while an operation is in progress
//   done       slave->master  one-cycle pulse when mulResult updates
// ---------------------------------------------------------------------------
interface math_multiplier_8bit_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [2*WIDTH-1:0]     mulResult;
    logic                   busy;
    logic                   done;

    modport master (
        output start, a, b,
        input  mulResult, busy, done
    );

    modport slave (
        input  start, a, b,
        output mulResult, busy, done
    );
endinterface

// File: rtl/math_multiplier_8bit_seq.sv
// ---------------------------------------------------------------------------
// math_multiplier_8bit_seq
//   Unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier. One multiplier
//   bit is consumed per clock; the product appears WIDTH cycles after a start
//   is accepted, together with a one-cycle done pulse.
//   clk    in   rising-edge system clock
//   rst_n  in   asynchronous active-low reset (aborts any operation in flight)
//   bus    slave side of math_multiplier_8bit_seq_if (start/a/b in,
//          mulResult/busy/done out)
// ---------------------------------------------------------------------------
module math_multiplier_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    math_multiplier_8bit_seq_if.slave   bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q,  state_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [PW-1:0]    result_q, result_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [PW-1:0]    acc_sum;

    // Partial-product accumulation for the current step; also the final
    // product on the last step, so it can be registered straight into the
    // result without an extra cycle.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    count_d  = CNT_W'(WIDTH);
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CNT_W'(1);
                // Last bit consumed this edge: publish and return to idle so
                // a new start can be accepted on the very next edge.
                if (count_q == CNT_W'(1)) begin
                    result_d = acc_sum;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.mulResult = result_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_math_multiplier_8bit_seq.sv
// ---------------------------------------------------------------------------
// tb_math_multiplier_8bit_seq
//   Self-checking bench for math_multiplier_8bit_seq. The reference is plain
//   a*b arithmetic plus the expected handshake timing (done 8 cycles after
//   acceptance, one cycle wide, 9-cycle back-to-back period).
// ---------------------------------------------------------------------------
module tb_math_multiplier_8bit_seq;
    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    logic [15:0] last_result;

    math_multiplier_8bit_seq_if #(.WIDTH(8)) bus ();

    math_multiplier_8bit_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation from idle and check product, latency, pulse width
    // and that the previous product is held while the operation runs.
    // scramble: change a/b every cycle during RUN; noise: toggle start
    // randomly while busy (must be ignored).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit scramble, input bit noise, input string tag);
        logic [15:0] exp;
        int          lat;
        bit          hold_ok;
        exp     = 16'(a) * 16'(b);
        hold_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            if (bus.mulResult !== last_result) hold_ok = 1'b0;
            if (scramble) begin
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end
            @(negedge clk);
            lat++;
            if (noise && !bus.done) bus.start = 1'($urandom_range(0, 1));
            else bus.start = 1'b0;
        end
        check_eq({tag, "_latency"}, lat, 8);
        check_eq({tag, "_result"}, bus.mulResult, exp);
        check_eq({tag, "_hold"}, hold_ok, 1);
        @(negedge clk);
        check_eq({tag, "_done_width"}, {bus.done, bus.busy}, 0);
        last_result = exp;
    endtask

    initial begin
        int  gap;
        bit  seen;
        n_tests     = 0;
        n_fail      = 0;
        last_result = 16'd0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = 8'd0;
        bus.b       = 8'd0;

        repeat (2) @(negedge clk);
        check_eq("reset_result", bus.mulResult, 0);
        check_eq("reset_busy", bus.busy, 0);
        check_eq("reset_done", bus.done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_no_start", {bus.busy, bus.done}, 0);

        // basic products
        run_op(8'd1,   8'd1, 1'b0, 1'b0, "p1x1");
        run_op(8'd15,  8'd2, 1'b0, 1'b0, "p15x2");
        run_op(8'd255, 8'd1, 1'b0, 1'b0, "p255x1");

        // patterns with operands changed mid-run
        run_op(8'd170, 8'd85,  1'b1, 1'b0, "p170x85");
        run_op(8'd128, 8'd128, 1'b1, 1'b0, "p128x128");

        // max, then zero operand with hold of the max product
        run_op(8'd255, 8'd255, 1'b0, 1'b0, "pmax");
        run_op(8'd0,   8'd200, 1'b0, 1'b0, "pzero");
        run_op(8'd77,  8'd0,   1'b0, 1'b1, "pzero_b");

        // back-to-back with start held high
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd12;
        bus.b     = 8'd13;
        gap = 0;
        while (!bus.done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check_eq("b2b_first_latency", gap, 9);
        check_eq("b2b_first_result", bus.mulResult, 156);
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!bus.done && gap < 20);
            check_eq("b2b_period", gap, 9);
            check_eq("b2b_result", bus.mulResult, 156);
        end
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("b2b_stop", {bus.busy, bus.done}, 0);
        last_result = 16'd156;

        // reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd200;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_result", bus.mulResult, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check_eq("abort_no_done", seen, 0);
        check_eq("abort_result_held", bus.mulResult, 0);
        last_result = 16'd0;

        // random pairs, with operand scrambling and start noise during RUN
        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'b1, 1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
